// File: rtl/qspi_pkg.sv
// Shared state encoding and command constants for the quad-SPI target.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_e;

  localparam logic [7:0]  CMD_READ_QUAD  = 8'hEB;
  localparam logic [7:0]  CMD_WRITE_QUAD = 8'h38;
  localparam int unsigned DUMMY_CYCLES   = 6;
  localparam int unsigned CMD_BITS       = 8;

  function automatic logic is_write_cmd(input logic [7:0] cmd);
    return cmd == CMD_WRITE_QUAD;
  endfunction

endpackage

// File: rtl/qspi_sync.sv
// Multi-stage synchronizer for one asynchronous bit; resets to 1 (idle level of SPI lines).
module qspi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ff_q <= '1;
    end else begin
      ff_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        ff_q[i] <= ff_q[i-1];
      end
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/qspi_target.sv
// Quad-SPI memory target: 0xEB quad read / 0x38 quad write onto a byte-wide backing store.
// Define QSPI_TARGET_CMD_CHECK_EN to reject unknown commands via cmd_error and an IGNORE state.
module qspi_target
  import qspi_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_clk,
  input  logic                 spi_cs_n,
  input  logic [3:0]           spi_data_in,
  output logic [3:0]           spi_data_out,
  output logic [3:0]           spi_data_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_wr,
  output logic [7:0]           mem_wdata,
  output logic                 busy,
  output logic                 cmd_error
);

  localparam int unsigned ADDR_NIBS = ADDR_BITS / 4;
  localparam int unsigned SR_W      = ADDR_BITS - 4;
  localparam int unsigned FLUSH_W   = $clog2(SYNC_STAGES + 1);

  logic       sclk_s;
  logic       cs_n_s;
  logic [3:0] din_s;

  qspi_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (.clk(clk), .rstn(rstn), .d_i(spi_clk),  .q_o(sclk_s));
  qspi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs  (.clk(clk), .rstn(rstn), .d_i(spi_cs_n), .q_o(cs_n_s));

  for (genvar i = 0; i < 4; i++) begin : g_sync_din
    qspi_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
      .clk(clk), .rstn(rstn), .d_i(spi_data_in[i]), .q_o(din_s[i])
    );
  end

  state_e                 state_q;
  logic                   busy_q;
  logic                   sclk_q;
  logic                   armed_q;
  logic [FLUSH_W-1:0]     flush_q;
  logic [SR_W-1:0]        sr_q;
  logic [2:0]             cnt_q;
  logic                   is_wr_q;
  logic [7:0]             tx_q;
  logic [7:0]             hold_q;
  logic                   nib_hi_q;
  logic                   rd_pend_q;
  logic                   rd_to_tx_q;
  logic [3:0]             whi_q;
  logic                   wnib_q;
  logic [3:0]             data_out_q;
  logic [3:0]             data_oe_q;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic                   mem_rd_q;
  logic                   mem_wr_q;
  logic [7:0]             mem_wdata_q;
`ifdef QSPI_TARGET_CMD_CHECK_EN
  logic                   cmd_error_q;
`endif

  logic                 rise;
  logic                 fall;
  logic                 flush_done;
  logic [7:0]           cmd_d;
  logic [ADDR_BITS-1:0] addr_d;

  assign rise       = sclk_s & ~sclk_q;
  assign fall       = ~sclk_s & sclk_q;
  assign flush_done = (flush_q == FLUSH_W'(SYNC_STAGES));
  assign cmd_d      = {sr_q[6:0], din_s[0]};
  assign addr_d     = {sr_q, din_s};

  // Protocol FSM plus memory-side datapath; deselect overrides every active state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      sclk_q      <= 1'b1;
      armed_q     <= 1'b0;
      flush_q     <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      tx_q        <= '0;
      hold_q      <= '0;
      nib_hi_q    <= 1'b1;
      rd_pend_q   <= 1'b0;
      rd_to_tx_q  <= 1'b0;
      whi_q       <= '0;
      wnib_q      <= 1'b0;
      data_out_q  <= 4'hF;
      data_oe_q   <= 4'h0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
`ifdef QSPI_TARGET_CMD_CHECK_EN
      cmd_error_q <= 1'b0;
`endif
    end else begin
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
`ifdef QSPI_TARGET_CMD_CHECK_EN
      cmd_error_q <= 1'b0;
`endif
      sclk_q    <= sclk_s;
      rd_pend_q <= mem_rd_q;
      if (!flush_done) flush_q <= flush_q + FLUSH_W'(1);
      if (mem_rd_q || mem_wr_q) mem_addr_q <= mem_addr_q + ADDR_BITS'(1);
      // Read data arrives one cycle after the strobe: first byte straight to tx, prefetches to hold.
      if (rd_pend_q) begin
        if (rd_to_tx_q) tx_q   <= mem_rdata;
        else            hold_q <= mem_rdata;
      end

      if (state_q != ST_IDLE && cs_n_s) begin
        state_q    <= ST_IDLE;
        busy_q     <= 1'b0;
        data_oe_q  <= 4'h0;
        data_out_q <= 4'hF;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // A start needs chip select seen high once the synchronizers have flushed.
            if (flush_done && cs_n_s) begin
              armed_q <= 1'b1;
            end else if (armed_q && !cs_n_s) begin
              armed_q <= 1'b0;
              state_q <= ST_CMD;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
            end
          end
          ST_CMD: begin
            if (rise) begin
              sr_q  <= {sr_q[SR_W-2:0], din_s[0]};
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'(CMD_BITS - 1)) begin
                cnt_q <= '0;
`ifdef QSPI_TARGET_CMD_CHECK_EN
                if (cmd_d == CMD_WRITE_QUAD || cmd_d == CMD_READ_QUAD) begin
                  is_wr_q <= is_write_cmd(cmd_d);
                  state_q <= ST_ADDR;
                end else begin
                  cmd_error_q <= 1'b1;
                  state_q     <= ST_IGNORE;
                end
`else
                is_wr_q <= is_write_cmd(cmd_d);
                state_q <= ST_ADDR;
`endif
              end
            end
          end
          ST_ADDR: begin
            if (rise) begin
              sr_q  <= addr_d[SR_W-1:0];
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'(ADDR_NIBS - 1)) begin
                cnt_q      <= '0;
                mem_addr_q <= addr_d;
                if (is_wr_q) begin
                  state_q <= ST_WDATA;
                  wnib_q  <= 1'b0;
                end else begin
                  state_q    <= ST_DUMMY;
                  mem_rd_q   <= 1'b1;
                  rd_to_tx_q <= 1'b1;
                end
              end
            end
          end
          ST_DUMMY: begin
            if (rise) begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'(DUMMY_CYCLES - 1)) begin
                state_q    <= ST_RDATA;
                data_oe_q  <= 4'hF;
                data_out_q <= tx_q[7:4];
                nib_hi_q   <= 1'b1;
              end
            end
          end
          ST_RDATA: begin
            // High nibble presentation also launches the prefetch of the following byte.
            if (fall) begin
              if (nib_hi_q) begin
                data_out_q <= tx_q[7:4];
                mem_rd_q   <= 1'b1;
                rd_to_tx_q <= 1'b0;
                nib_hi_q   <= 1'b0;
              end else begin
                data_out_q <= tx_q[3:0];
                tx_q       <= hold_q;
                nib_hi_q   <= 1'b1;
              end
            end
          end
          ST_WDATA: begin
            if (rise) begin
              if (!wnib_q) begin
                whi_q  <= din_s;
                wnib_q <= 1'b1;
              end else begin
                mem_wdata_q <= {whi_q, din_s};
                mem_wr_q    <= 1'b1;
                wnib_q      <= 1'b0;
              end
            end
          end
          ST_IGNORE: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi_data_out = data_out_q;
  assign spi_data_oe  = data_oe_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
`ifdef QSPI_TARGET_CMD_CHECK_EN
  assign cmd_error    = cmd_error_q;
`else
  assign cmd_error    = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_target.sv
// Directed bench for qspi_target: reads, writes, address wrap, partial write, bad command, mid-read reset.
module tb_qspi_target;

  localparam int unsigned HALF = 4;
  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_clk = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic [3:0]  spi_data_in = 4'h0;
  logic [3:0]  spi_data_out;
  logic [3:0]  spi_data_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        cmd_error;

  int vec_cnt = 0;
  int err_cnt = 0;
  int err_pulses = 0;

  logic [7:0]  mem [logic [23:0]];
  logic [23:0] rd_log [$];
  logic [31:0] wr_log [$];

  always #5 clk = ~clk;

  qspi_target #(.ADDR_BITS(24), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rstn(rstn), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .busy(busy), .cmd_error(cmd_error)
  );

  // Backing store: registered read data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
      rd_log.push_back(mem_addr);
    end
    if (mem_wr) begin
      mem[mem_addr] = mem_wdata;
      wr_log.push_back({mem_addr, mem_wdata});
    end
    if (cmd_error) err_pulses++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic spi_cycle(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    spi_clk = 1'b0;
    spi_data_in = d;
    repeat (HALF) @(negedge clk);
    q  = spi_data_out;
    oe = spi_data_oe;
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_low;
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high;
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    logic [3:0] q, oe;
    for (int i = 7; i >= 0; i--) spi_cycle({3'b000, c[i]}, q, oe);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] q, oe;
    for (int i = 5; i >= 0; i--) spi_cycle(a[i*4 +: 4], q, oe);
  endtask

  task automatic send_dummy(output logic [3:0] oe_any);
    logic [3:0] q, oe;
    oe_any = 4'h0;
    for (int i = 0; i < 6; i++) begin
      spi_cycle(4'h0, q, oe);
      oe_any = oe_any | oe;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if (spi_data_oe !== 4'h0) begin err_cnt++; $display("FAIL rst_oe: got %h expected 0", spi_data_oe); end
    vec_cnt++; if (spi_data_out !== 4'hF) begin err_cnt++; $display("FAIL rst_out: got %h expected f", spi_data_out); end
    vec_cnt++; if ({mem_rd, mem_wr, cmd_error, busy} !== 4'b0000) begin err_cnt++; $display("FAIL rst_strobes: got %b expected 0000", {mem_rd, mem_wr, cmd_error, busy}); end
    vec_cnt++; if (mem_addr !== 24'h0) begin err_cnt++; $display("FAIL rst_addr: got %h expected 000000", mem_addr); end
    vec_cnt++; if (mem_wdata !== 8'h0) begin err_cnt++; $display("FAIL rst_wdata: got %h expected 00", mem_wdata); end
    rstn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_read;
    logic [3:0] q, oe, oe_any;
    logic [3:0] exp [8];
    exp = '{4'hA, 4'h5, 4'h3, 4'hC, 4'h0, 4'h0, 4'hF, 4'hF};
    rd_log.delete();
    cs_low();
    send_cmd(8'hEB);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL read_busy: got %b expected 1", busy); end
    send_addr(24'h000010);
    send_dummy(oe_any);
    vec_cnt++; if (oe_any !== 4'h0) begin err_cnt++; $display("FAIL read_dummy_oe: got %h expected 0", oe_any); end
    for (int i = 0; i < 8; i++) begin
      spi_cycle(4'h0, q, oe);
      vec_cnt++; if (q !== exp[i]) begin err_cnt++; $display("FAIL read_nib%0d: got %h expected %h", i, q, exp[i]); end
      if (i == 0) begin
        vec_cnt++; if (oe !== 4'hF) begin err_cnt++; $display("FAIL read_oe: got %h expected f", oe); end
      end
    end
    cs_high();
    vec_cnt++; if (rd_log.size() != 5) begin err_cnt++; $display("FAIL read_rd_count: got %0d expected 5", rd_log.size()); end
    for (int i = 0; i < rd_log.size() && i < 5; i++) begin
      vec_cnt++; if (rd_log[i] !== 24'h10 + 24'(i)) begin err_cnt++; $display("FAIL read_rd_addr%0d: got %h expected %h", i, rd_log[i], 24'h10 + 24'(i)); end
    end
    vec_cnt++; if ({busy, spi_data_oe, spi_data_out} !== {1'b0, 4'h0, 4'hF}) begin err_cnt++; $display("FAIL read_idle: got %b/%h/%h expected 0/0/f", busy, spi_data_oe, spi_data_out); end
  endtask

  task automatic test_write;
    logic [3:0] q, oe;
    logic [3:0] nibs [4];
    nibs = '{4'hD, 4'hE, 4'hA, 4'hD};
    wr_log.delete();
    cs_low();
    send_cmd(8'h38);
    send_addr(24'h123456);
    for (int i = 0; i < 4; i++) spi_cycle(nibs[i], q, oe);
    cs_high();
    vec_cnt++; if (wr_log.size() != 2) begin err_cnt++; $display("FAIL write_count: got %0d expected 2", wr_log.size()); end
    if (wr_log.size() >= 2) begin
      vec_cnt++; if (wr_log[0] !== 32'h123456DE) begin err_cnt++; $display("FAIL write_0: got %h expected 123456de", wr_log[0]); end
      vec_cnt++; if (wr_log[1] !== 32'h123457AD) begin err_cnt++; $display("FAIL write_1: got %h expected 123457ad", wr_log[1]); end
    end
  endtask

  task automatic test_wrap;
    logic [3:0] q, oe, oe_any;
    logic [3:0] exp [4];
    int n;
    exp = '{4'h5, 4'hA, 4'hC, 4'h3};
    mem[24'hFFFFFF] = 8'h5A;
    mem[24'h000000] = 8'hC3;
    rd_log.delete();
    cs_low();
    send_cmd(8'hEB);
    send_addr(24'hFFFFFF);
    send_dummy(oe_any);
    for (int i = 0; i < 4; i++) begin
      spi_cycle(4'h0, q, oe);
      vec_cnt++; if (q !== exp[i]) begin err_cnt++; $display("FAIL wrap_nib%0d: got %h expected %h", i, q, exp[i]); end
    end
    vec_cnt++; if (rd_log.size() < 2 || rd_log[1] !== 24'h000000) begin err_cnt++; $display("FAIL wrap_addr: got %0d entries, second %h expected 000000", rd_log.size(), rd_log.size() >= 2 ? rd_log[1] : 24'hx); end
    spi_cs_n = 1'b1;
    n = 0;
    for (int i = 0; i < SYNC + 2; i++) begin
      @(negedge clk);
      n++;
      if (spi_data_oe === 4'h0) break;
    end
    vec_cnt++; if (spi_data_oe !== 4'h0) begin err_cnt++; $display("FAIL deselect_oe: got %h after %0d clk expected 0", spi_data_oe, n); end
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic test_partial_write;
    logic [3:0] q, oe;
    wr_log.delete();
    cs_low();
    send_cmd(8'h38);
    send_addr(24'h000200);
    spi_cycle(4'h1, q, oe);
    spi_cycle(4'h2, q, oe);
    spi_cycle(4'h3, q, oe);
    spi_cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    vec_cnt++; if ({busy, spi_data_oe} !== 5'b0) begin err_cnt++; $display("FAIL partial_idle: got busy %b oe %h expected 0/0", busy, spi_data_oe); end
    repeat (2 * HALF) @(negedge clk);
    vec_cnt++; if (wr_log.size() != 1) begin err_cnt++; $display("FAIL partial_count: got %0d expected 1", wr_log.size()); end
    if (wr_log.size() >= 1) begin
      vec_cnt++; if (wr_log[0] !== 32'h00020012) begin err_cnt++; $display("FAIL partial_data: got %h expected 00020012", wr_log[0]); end
    end
  endtask

  task automatic test_bad_cmd;
    logic [3:0] q, oe, oe_any;
    err_pulses = 0;
    rd_log.delete();
    wr_log.delete();
    cs_low();
    send_cmd(8'h9F);
`ifdef QSPI_TARGET_CMD_CHECK_EN
    oe_any = 4'h0;
    for (int i = 0; i < 14; i++) begin
      spi_cycle(4'h5, q, oe);
      oe_any = oe_any | oe;
    end
    cs_high();
    vec_cnt++; if (err_pulses != 1) begin err_cnt++; $display("FAIL badcmd_err: got %0d pulses expected 1", err_pulses); end
    vec_cnt++; if (rd_log.size() + wr_log.size() != 0) begin err_cnt++; $display("FAIL badcmd_strobes: got %0d expected 0", rd_log.size() + wr_log.size()); end
    vec_cnt++; if (oe_any !== 4'h0) begin err_cnt++; $display("FAIL badcmd_oe: got %h expected 0", oe_any); end
`else
    send_addr(24'h000010);
    send_dummy(oe_any);
    spi_cycle(4'h0, q, oe);
    vec_cnt++; if (q !== 4'hA) begin err_cnt++; $display("FAIL badcmd_read_hi: got %h expected a", q); end
    spi_cycle(4'h0, q, oe);
    vec_cnt++; if (q !== 4'h5) begin err_cnt++; $display("FAIL badcmd_read_lo: got %h expected 5", q); end
    cs_high();
    vec_cnt++; if (err_pulses != 0) begin err_cnt++; $display("FAIL badcmd_err: got %0d pulses expected 0", err_pulses); end
`endif
    // Following normal read right behind it
    cs_low();
    send_cmd(8'hEB);
    send_addr(24'h000011);
    send_dummy(oe_any);
    spi_cycle(4'h0, q, oe);
    vec_cnt++; if (q !== 4'h3) begin err_cnt++; $display("FAIL b2b_read_hi: got %h expected 3", q); end
    spi_cycle(4'h0, q, oe);
    vec_cnt++; if (q !== 4'hC) begin err_cnt++; $display("FAIL b2b_read_lo: got %h expected c", q); end
    cs_high();
  endtask

  task automatic test_reset_mid;
    logic [3:0] q, oe, oe_any;
    logic [3:0] exp [4];
    exp = '{4'h0, 4'h0, 4'hF, 4'hF};
    cs_low();
    send_cmd(8'hEB);
    send_addr(24'h000010);
    send_dummy(oe_any);
    for (int i = 0; i < 3; i++) spi_cycle(4'h0, q, oe);
    rstn = 1'b0;
    @(negedge clk);
    vec_cnt++; if ({spi_data_oe, spi_data_out} !== 8'h0F) begin err_cnt++; $display("FAIL midrst_pins: got oe %h out %h expected 0/f", spi_data_oe, spi_data_out); end
    vec_cnt++; if ({busy, mem_rd, mem_wr, cmd_error} !== 4'b0) begin err_cnt++; $display("FAIL midrst_ctl: got %b expected 0000", {busy, mem_rd, mem_wr, cmd_error}); end
    vec_cnt++; if ({mem_addr, mem_wdata} !== 32'h0) begin err_cnt++; $display("FAIL midrst_addr: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    // Chip select still low from the abandoned transfer: must not start
    repeat (4 * HALF) @(negedge clk);
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL midrst_nostart: got busy %b expected 0", busy); end
    cs_high();
    cs_low();
    send_cmd(8'hEB);
    send_addr(24'h000012);
    send_dummy(oe_any);
    for (int i = 0; i < 4; i++) begin
      spi_cycle(4'h0, q, oe);
      vec_cnt++; if (q !== exp[i]) begin err_cnt++; $display("FAIL midrst_read%0d: got %h expected %h", i, q, exp[i]); end
    end
    cs_high();
  endtask

  initial begin
    mem[24'h000010] = 8'hA5;
    mem[24'h000011] = 8'h3C;
    mem[24'h000012] = 8'h00;
    mem[24'h000013] = 8'hFF;
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_wrap();
    test_partial_write();
    test_bad_cmd();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/qspi_target.md
QSPI_TARGET -- requirements
Module: qspi_target

Interface
REQ-001 Parameter ADDR_BITS, default 24: address width; only 24 SHALL be supported.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on spi_clk, spi_cs_n and spi_data_in.
REQ-003 clk  input  1: system clock, SHALL be at least 4x the SPI clock frequency.
REQ-004 rstn  input  1: reset, synchronous, active-low.
REQ-005 spi_clk  input  1: SPI clock from the initiator, idle high.
REQ-006 spi_cs_n  input  1: chip select, active-low.
REQ-007 spi_data_in  input  4: SPI data lines from the initiator.
REQ-008 spi_data_out  output  4: SPI data driven to the initiator.
REQ-009 spi_data_oe  output  4: per-line output enable.
REQ-010 mem_addr  output  24: backing-store byte address.
REQ-011 mem_rd  output  1: one-cycle read strobe.
REQ-012 mem_rdata  input  8: read data, valid exactly 1 clk after mem_rd.
REQ-013 mem_wr  output  1: one-cycle write strobe.
REQ-014 mem_wdata  output  8: write data, valid with mem_wr.
REQ-015 busy  output  1: high when state is not IDLE.
REQ-016 cmd_error  output  1: one-cycle pulse on an unsupported command.

Function
REQ-017 Edges SHALL be detected on the synchronized spi_clk: rise = sample, fall = drive.
REQ-018 States SHALL be IDLE, CMD, ADDR, DUMMY, RDATA, WDATA and IGNORE.
REQ-019 IDLE -> CMD SHALL occur on synchronized spi_cs_n falling.
REQ-020 CMD SHALL shift in 8 bits from spi_data_in[0], MSB first, on rises.
REQ-021 After the 8th bit, 0xEB SHALL go to ADDR as a read and 0x38 SHALL go to ADDR as a write.
REQ-022 ADDR SHALL shift in 6 nibbles, MSB nibble first.
REQ-023 After the 6th nibble, a read SHALL go to DUMMY with count 6 and a write SHALL go to WDATA.
REQ-024 On entering DUMMY, mem_rd SHALL pulse with mem_addr set to the received address.
REQ-025 On the next clk, mem_rdata SHALL be latched into the tx shift register, and mem_addr SHALL increment.
REQ-026 DUMMY SHALL ignore spi_data_in for 6 rises and keep spi_data_oe at 0.
REQ-027 RDATA SHALL set spi_data_oe=4'b1111 and present the high nibble by the fall following the 6th dummy rise.
REQ-028 RDATA SHALL advance one nibble per fall, high nibble then low nibble.
REQ-029 When the high nibble of a byte is presented, the next byte SHALL be prefetched (mem_rd pulse) into a holding register.
REQ-030 WDATA SHALL shift nibbles on rises, high nibble first.
REQ-031 On each 2nd nibble of WDATA, mem_wr SHALL pulse within 2 clk with mem_wdata = assembled byte, then mem_addr SHALL increment.
REQ-032 Address increment SHALL wrap from 0xFFFFFF to 0x000000.
REQ-033 On synchronized spi_cs_n rising in any state, the block SHALL go to IDLE and set spi_data_oe=0.
REQ-034 A write nibble count that is odd at deselect SHALL discard the partial byte with no mem_wr.
REQ-035 Rises while spi_cs_n is high SHALL be ignored.
REQ-036 spi_data_out SHALL be 4'b1111 whenever spi_data_oe=0.

Reset
REQ-037 rstn low SHALL set: state IDLE, spi_data_oe=0, spi_data_out=4'b1111, mem_rd=0, mem_wr=0, cmd_error=0, mem_addr=0, mem_wdata=0, synchronizers to 1.
REQ-038 A transaction active when reset is asserted SHALL be abandoned.
REQ-039 After reset, the first transaction SHALL be accepted only after spi_cs_n is observed high.

Configuration
REQ-040 With QSPI_TARGET_CMD_CHECK_EN defined, any command other than 0xEB or 0x38 SHALL pulse cmd_error and enter IGNORE until deselect, with no mem_rd or mem_wr.
REQ-041 Without QSPI_TARGET_CMD_CHECK_EN, command 0x38 SHALL be a write, every other command SHALL be a read, and cmd_error SHALL be tied 0.

Structure
REQ-042 A package qspi_pkg SHALL hold the state enum, the command constants CMD_READ_QUAD=0xEB and CMD_WRITE_QUAD=0x38, and DUMMY_CYCLES=6.
REQ-043 A sub-module qspi_sync SHALL implement the SYNC_STAGES-deep synchronizer with reset value 1, instantiated per input bit.

Verification
REQ-044 Read 0xEB at address 0x000010, memory[0x10..0x13]=A5,3C,00,FF, 8 data nibbles -> out A,5,3,C,0,0,F,F; mem_rd addresses 0x10..0x14.
REQ-045 Write 0x38 at address 0x123456 with data 0xDE,0xAD -> mem_wr twice: (0x123456,DE), (0x123457,AD).
REQ-046 Read at 0xFFFFFF, 2 bytes -> second byte fetched from 0x000000.
REQ-047 Write 3 nibbles then deselect -> exactly one mem_wr; oe=0 within SYNC_STAGES+2 clk.
REQ-048 Command 0x9F with macro defined -> cmd_error pulses once, no memory strobes, oe stays 0 until deselect; next 0xEB transaction is normal.
REQ-049 rstn asserted mid-RDATA -> all outputs take reset values next clk; a subsequent read is correct.
